// File: rtl/nrzi_tx_pkg.sv
// Shared types and helpers for the NRZI DDR transmit stream.
// Holds the serializer state encoding and the dibit-counter width function.
// No ports; imported by nrzi_lane_enc and nrzi_ddr_tx_stream.
package nrzi_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Width of the per-word dibit counter; a word holds word_w/2 dibits.
    function automatic int dibit_cnt_w(input int word_w);
        return (word_w / 2 > 1) ? $clog2(word_w / 2) : 1;
    endfunction

endpackage

// File: rtl/nrzi_lane_enc.sv
// One lane of NRZI line coding: holds the line level and produces the two
// half-period levels. Ports: clkp/_rst, emit (dibit valid this edge), tog
// (invert the idle line), dibit {b1,b0}, q0/q1 registered DDR data.
module nrzi_lane_enc
    import nrzi_tx_pkg::*;
(
    input  logic       clkp,
    input  logic       _rst,
    input  logic       emit,
    input  logic       tog,
    input  logic [1:0] dibit,
    output logic       q0,
    output logic       q1
);

    // The line level L is simply the registered q1: whatever the line
    // settled to at the end of the previous period.
    always_ff @(posedge clkp or negedge _rst) begin
        if (!_rst) begin
            q0 <= 1'b0;
            q1 <= 1'b0;
        end else if (emit) begin
            q0 <= q1 ^ dibit[1];
            q1 <= q1 ^ dibit[1] ^ dibit[0];
        end else if (tog) begin
            q0 <= ~q1;
            q1 <= ~q1;
        end else begin
            q0 <= q1;
        end
    end

endmodule

// File: rtl/nrzi_ddr_tx_stream.sv
// Streaming NRZI transmitter: words enter a small FIFO, are serialized MSB
// first as dibits per lane and NRZI coded onto q0/q1 for a DDR output cell.
// Ports: s_data/s_valid/s_last/s_ready input stream, toggle, abort, q0/q1, run, last.
module nrzi_ddr_tx_stream
    import nrzi_tx_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
)
(
    input  logic                    clkp,
    input  logic                    _rst,
    input  logic [LANES*WORD_W-1:0] s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    input  logic                    toggle,
    input  logic                    abort,
    output logic [LANES-1:0]        q0,
    output logic [LANES-1:0]        q1,
    output logic                    run,
    output logic                    last
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = dibit_cnt_w(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W / 2 - 1);
    localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);

    typedef struct packed {
        logic                    last;
        logic [LANES*WORD_W-1:0] data;
    } entry_t;

    entry_t                  mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
    logic                    empty, push, pop;
    ser_state_t              state, state_nxt;
    logic [CNT_W-1:0]        dcnt;
    logic [LANES*WORD_W-1:0] shreg, sh_nxt;
    logic                    cur_last;
    logic                    emit, fin, tog;

    assign empty = (wr_ptr == rd_ptr);
    // s_ready is registered low at full, so a push can never collide with
    // a pop at full occupancy.
    assign push  = s_valid && s_ready && !abort;

    // ---------------- FIFO ----------------
    always_comb begin
        wr_nxt = wr_ptr + PTR_W'(push);
        rd_nxt = rd_ptr + PTR_W'(pop);
        if (abort) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end
        cnt_nxt = wr_nxt - rd_nxt;
    end

    always_ff @(posedge clkp or negedge _rst) begin
        if (!_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            s_ready <= 1'b0;
        end else begin
            wr_ptr  <= wr_nxt;
            rd_ptr  <= rd_nxt;
            s_ready <= (cnt_nxt < DEPTH_P);
        end
    end

    always_ff @(posedge clkp) begin
        if (push)
            mem[wr_ptr[PTR_W-2:0]] <= '{last: s_last, data: s_data};
    end

    // ---------------- serializer FSM ----------------
    always_ff @(posedge clkp or negedge _rst) begin
        if (!_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (!empty) state_nxt = ST_SHIFT;
                ST_SHIFT: if (fin && empty) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        emit = 1'b0;
        fin  = 1'b0;
        pop  = 1'b0;
        tog  = 1'b0;
        if (!abort) begin
            case (state)
                ST_IDLE: begin
                    pop = !empty;
                    tog = toggle && empty;
                end
                ST_SHIFT: begin
                    emit = 1'b1;
                    fin  = (dcnt == CNT_LAST);
                    // Final dibit chains straight into the next word.
                    pop  = fin && !empty;
                end
                default: ;
            endcase
        end
    end

    // ---------------- shift register and status ----------------
    always_ff @(posedge clkp or negedge _rst) begin
        if (!_rst) begin
            dcnt     <= '0;
            shreg    <= '0;
            cur_last <= 1'b0;
            run      <= 1'b0;
            last     <= 1'b0;
        end else begin
            run  <= emit;
            last <= emit && fin && cur_last;
            if (pop) begin
                shreg    <= mem[rd_ptr[PTR_W-2:0]].data;
                cur_last <= mem[rd_ptr[PTR_W-2:0]].last;
                dcnt     <= '0;
            end else if (emit) begin
                shreg <= sh_nxt;
                dcnt  <= dcnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sh_nxt[i*WORD_W +: WORD_W] = {shreg[i*WORD_W +: WORD_W-2], 2'b00};

        nrzi_lane_enc u_enc (
            .clkp  (clkp),
            ._rst  (_rst),
            .emit  (emit),
            .tog   (tog),
            .dibit (shreg[i*WORD_W + WORD_W - 2 +: 2]),
            .q0    (q0[i]),
            .q1    (q1[i])
        );
    end

endmodule

// File: tb/tb_nrzi_ddr_tx_stream.sv
// Directed bench for nrzi_ddr_tx_stream with LANES=1, WORD_W=8, DEPTH=4.
// Table rows give inputs for one edge and the outputs expected after it;
// multi-cycle cases (FIFO fill, async reset) are hand-written sequences.
module tb_nrzi_ddr_tx_stream;

    logic       clkp;
    logic       _rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       toggle;
    logic       abort;
    logic [0:0] q0;
    logic [0:0] q1;
    logic       run;
    logic       last;

    nrzi_ddr_tx_stream #(.LANES(1), .WORD_W(8), .DEPTH(4)) dut (
        .clkp    (clkp),
        ._rst    (_rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .toggle  (toggle),
        .abort   (abort),
        .q0      (q0),
        .q1      (q1),
        .run     (run),
        .last    (last)
    );

    initial clkp = 1'b0;
    always #5 clkp = ~clkp;

    typedef struct {
        logic [7:0] d;
        logic v, sl, tg, ab;
        logic q0, q1, run, last, rdy;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] words [7];
    int         in_i, out_i, dib, cyc;
    logic [7:0] acc;
    logic       prev_l, saw_full, acc_ok;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic row(input logic [7:0] d, input logic v, sl, tg, ab,
                       input logic eq0, eq1, erun, elast, erdy);
        vec_t t;
        t.d = d; t.v = v; t.sl = sl; t.tg = tg; t.ab = ab;
        t.q0 = eq0; t.q1 = eq1; t.run = erun; t.last = elast; t.rdy = erdy;
        tbl.push_back(t);
    endtask

    task automatic apply(input vec_t t, input string tag);
        s_data  = t.d;
        s_valid = t.v;
        s_last  = t.sl;
        toggle  = t.tg;
        abort   = t.ab;
        @(posedge clkp);
        #1;
        check(tag, {3'b000, q0[0], q1[0], run, last, s_ready},
                   {3'b000, t.q0, t.q1, t.run, t.last, t.rdy});
    endtask

    initial begin
        //        d     v  sl tg ab   q0 q1 run last rdy
        // 0xB4 from reset: dibits 10,11,01,00
        row(8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 1);  // 0 first edge out of reset
        row(8'hB4, 1, 0, 0, 0,  0, 0, 0, 0, 1);  // 1 push (edge k)
        row(8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 1);  // 2 pop, lines hold
        row(8'h00, 0, 0, 0, 0,  1, 1, 1, 0, 1);  // 3
        row(8'h00, 0, 0, 0, 0,  0, 1, 1, 0, 1);  // 4
        row(8'h00, 0, 0, 0, 0,  1, 0, 1, 0, 1);  // 5
        row(8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 1);  // 6
        row(8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 1);  // 7 idle again, L=0
        // idle toggle
        row(8'h00, 0, 0, 1, 0,  1, 1, 0, 0, 1);  // 8
        row(8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 1);  // 9 held
        // 0xFF then 0x00 (last) back-to-back, toggles ignored
        row(8'hFF, 1, 0, 0, 0,  1, 1, 0, 0, 1);  // 10
        row(8'h00, 1, 1, 1, 0,  1, 1, 0, 0, 1);  // 11 toggle during pop
        row(8'h00, 0, 0, 1, 0,  0, 1, 1, 0, 1);  // 12 toggle during shift
        row(8'h00, 0, 0, 1, 0,  0, 1, 1, 0, 1);  // 13
        row(8'h00, 0, 0, 0, 0,  0, 1, 1, 0, 1);  // 14
        row(8'h00, 0, 0, 0, 0,  0, 1, 1, 0, 1);  // 15 final of 0xFF, chain
        row(8'h00, 0, 0, 0, 0,  1, 1, 1, 0, 1);  // 16
        row(8'h00, 0, 0, 0, 0,  1, 1, 1, 0, 1);  // 17
        row(8'h00, 0, 0, 0, 0,  1, 1, 1, 0, 1);  // 18
        row(8'h00, 0, 0, 0, 0,  1, 1, 1, 1, 1);  // 19 last
        row(8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 1);  // 20
        // abort after second dibit of 0xB4, with a queued word
        row(8'h00, 0, 0, 1, 0,  0, 0, 0, 0, 1);  // 21 toggle back to L=0
        row(8'hB4, 1, 0, 0, 0,  0, 0, 0, 0, 1);  // 22
        row(8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 1);  // 23
        row(8'h55, 1, 0, 0, 0,  1, 1, 1, 0, 1);  // 24 queue 0x55
        row(8'h00, 0, 0, 0, 0,  0, 1, 1, 0, 1);  // 25 second dibit
        row(8'hAA, 1, 0, 1, 1,  1, 1, 0, 0, 1);  // 26 abort
        row(8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 1);  // 27
        row(8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 1);  // 28 nothing left to send
        row(8'h00, 0, 0, 1, 1,  1, 1, 0, 0, 1);  // 29 abort beats toggle
        row(8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 1);  // 30

        words[0] = 8'h1E; words[1] = 8'h2D; words[2] = 8'h3C; words[3] = 8'h4B;
        words[4] = 8'h5A; words[5] = 8'h69; words[6] = 8'h78;

        _rst = 1'b0; s_data = '0; s_valid = 0; s_last = 0; toggle = 0; abort = 0;
        repeat (2) @(posedge clkp);
        #1;
        check("reset_state", {3'b000, q0[0], q1[0], run, last, s_ready}, 8'h00);
        @(negedge clkp);
        _rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("row%0d", i));

        // Hold s_valid over seven words: FIFO must fill and all words
        // must come out once, in order, decoded from the line.
        in_i = 0; out_i = 0; dib = 0; cyc = 0; acc = '0; saw_full = 0;
        prev_l = q1[0];
        s_valid = 1; s_data = words[0]; s_last = 0;
        while (out_i < 7 && cyc < 200) begin
            acc_ok = s_valid && s_ready;
            @(posedge clkp);
            #1;
            cyc++;
            if (acc_ok) begin
                in_i++;
                if (in_i < 7) begin
                    s_data = words[in_i];
                    s_last = (in_i == 6);
                end else begin
                    s_valid = 0;
                    s_last  = 0;
                end
            end
            if (!s_ready) saw_full = 1;
            if (run) begin
                acc = {acc[5:0], q0[0] ^ prev_l, q1[0] ^ q0[0]};
                check($sformatf("last_w%0d_d%0d", out_i, dib), {7'd0, last},
                      {7'd0, (dib == 3 && out_i == 6)});
                dib++;
                if (dib == 4) begin
                    if (out_i < 7) check($sformatf("word%0d", out_i), acc, words[out_i]);
                    out_i++;
                    dib = 0;
                end
            end
            prev_l = q1[0];
        end
        check("words_out", 8'(out_i), 8'd7);
        check("ready_low_at_full", {7'd0, saw_full}, 8'd1);
        repeat (3) begin
            @(posedge clkp);
            #1;
            check("no_extra_word", {7'd0, run}, 8'd0);
        end

        // Asynchronous reset in the middle of a word.
        s_data = 8'hB4; s_valid = 1; s_last = 0;
        @(posedge clkp);
        #1;
        s_valid = 0;
        cyc = 0;
        while (!run && cyc < 10) begin
            @(posedge clkp);
            #1;
            cyc++;
        end
        check("pre_reset_run", {7'd0, run}, 8'd1);
        @(posedge clkp);
        #2;
        _rst = 1'b0;
        #1;
        check("async_reset", {3'b000, q0[0], q1[0], run, last, s_ready}, 8'h00);
        @(posedge clkp);
        @(negedge clkp);
        _rst = 1'b1;
        for (int i = 0; i < 8; i++)
            apply(tbl[i], $sformatf("post_reset_row%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrzi_ddr_tx_stream.md
NRZI_DDR_TX_STREAM -- requirements
Module: nrzi_ddr_tx_stream

Interface
REQ-001 Parameter LANES, default 1, number of parallel NRZI lanes (1..8).
REQ-002 Parameter WORD_W, default 8, bits per lane per word, even, 4..32.
REQ-003 Parameter DEPTH, default 4, input FIFO depth in words, power of 2, >=2.
REQ-004 clkp  input  1  transmit clock, all state on rising edge.
REQ-005 _rst  input  1  reset, asynchronous, active-low.
REQ-006 s_data  input  LANES*WORD_W  word; lane i uses bits [i*WORD_W +: WORD_W].
REQ-007 s_valid  input  1  word offered.
REQ-008 s_last  input  1  word closes a frame; travels with s_data.
REQ-009 s_ready  output  1  FIFO can accept a word.
REQ-010 toggle  input  1  request one line transition per lane while idle.
REQ-011 abort  input  1  synchronous flush.
REQ-012 q0  output  LANES  first-half-period level per lane, feeds DDR primitive D0.
REQ-013 q1  output  LANES  second-half-period level per lane, feeds DDR primitive D1.
REQ-014 run  output  1  high while a dibit is being emitted.
REQ-015 last  output  1  high in the cycle emitting the final dibit of an s_last word.

Function
REQ-016 Transfer occurs on an edge with s_valid && s_ready; word and s_last written to FIFO.
REQ-017 s_ready SHALL equal (occupancy < DEPTH), registered; simultaneous push and pop at full SHALL NOT be accepted.
REQ-018 Serializer states: IDLE, SHIFT.
REQ-019 IDLE with FIFO non-empty: pop word into shift register, go to SHIFT; q0/q1 hold.
REQ-020 SHIFT: each edge emits the top dibit (MSB first) per lane; word lasts WORD_W/2 edges.
REQ-021 On the edge emitting the final dibit: pop the next word if FIFO non-empty (stay SHIFT, no gap), else go to IDLE.
REQ-022 Latency: word pushed into an empty FIFO at edge k with serializer IDLE -> popped at k+1, first dibit on q0/q1 after edge k+2.
REQ-023 NRZI per lane, level L = previous q1, dibit (b1,b0): q0 = L^b1, q1 = q0^b0; L updates to q1.
REQ-024 Not emitting: q0 = q1 = L.
REQ-025 toggle in IDLE with FIFO empty: q0 = q1 = ~L on all lanes for that edge; ignored in SHIFT or when a pop occurs.
REQ-026 run high exactly on edges emitting a dibit; last = run && final dibit && word's s_last.
REQ-027 abort: next edge empties FIFO, state IDLE, run/last low, q0 = q1 = L (line level held); s_valid ignored that edge; abort has priority over toggle.
REQ-028 Counters: dibit counter clog2(WORD_W/2) bits, FIFO pointers clog2(DEPTH)+1 bits, wrap modulo.

Reset
REQ-029 _rst low: q0, q1, L all 0; run, last 0; FIFO empty; state IDLE; s_ready 1 after first edge with _rst high.
REQ-030 Reset mid-word SHALL discard the word and FIFO contents, outputs to 0 immediately.

Structure
REQ-031 Package nrzi_tx_pkg holds state encoding and dibit-count width function.
REQ-032 Sub-module nrzi_lane_enc: one lane's level register and REQ-023/024/025 logic, instantiated LANES times; FIFO inline.

Verification (LANES=1, WORD_W=8, DEPTH=4)
REQ-033 Reset, push 0xB4 -> (q0,q1) = (1,1),(0,1),(1,0),(0,0) on edges k+2..k+5, run high 4 cycles.
REQ-034 Push 0xFF then 0x00 back-to-back, s_last on second -> run high 8 contiguous cycles, last only on 8th.
REQ-035 Push 7 words with s_valid held -> s_ready low at full, all 7 words out in order, none dropped or duplicated.
REQ-036 Idle, L=0, toggle pulse -> q0=q1=1 one edge later, then held; toggle during SHIFT changes nothing.
REQ-037 abort after 2nd dibit of 0xB4 -> run low next edge, q0=q1=1 held, s_ready high, FIFO empty.
REQ-038 _rst low mid-word -> q0, q1, run 0 asynchronously; next word after release starts from L=0.
